// File: rtl/exception_commit_ctrl.sv
// exception_commit_ctrl: sequences exception/ERET commit after the MEM-stage
// decoder resolves a trap. The controller waits out any MEM-stage cache stall,
// then gives CP0 a one-cycle update together with a pipeline flush. After that
// it holds a PC redirect until instruction fetch accepts it.
// Optional feature: define EXC_COMMIT_CNT_EN to enable the exc_count counter
// of non-ERET exceptions taken. When it is undefined, exc_count is tied to 0.
module exception_commit_ctrl #(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_valid,
    input  logic            exc_eret,
    input  logic [4:0]      exc_code,
    input  logic [PC_W-1:0] exc_pc,
    input  logic            exc_is_ds,
    input  logic [PC_W-1:0] exc_badvaddr,
    input  logic [PC_W-1:0] cp0_epc,
    input  logic            mem_stall,
    input  logic            if_redir_ready,
    output logic            busy,
    output logic            flush_all,
    output logic            redir_valid,
    output logic [PC_W-1:0] redir_target,
    output logic            cp0_exc_we,
    output logic            cp0_eret_we,
    output logic [4:0]      cp0_exc_code,
    output logic            cp0_bd,
    output logic [PC_W-1:0] cp0_epc_wdata,
    output logic            cp0_badv_we,
    output logic [PC_W-1:0] cp0_badv_wdata,
    output logic [31:0]     exc_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMMIT   = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t          state_q;
    state_t          next_state;
    logic            accept;
    logic            eret_q;
    logic [4:0]      code_q;
    logic            bd_q;
    logic [PC_W-1:0] epc_wdata_q;
    logic [PC_W-1:0] badv_q;
    logic [PC_W-1:0] target_q;

    // A trap is taken only from IDLE, and only once the MEM stage is no longer frozen
    assign accept = (state_q == IDLE) && exc_valid && !mem_stall;

    // State register; reset drops any pending commit or redirect immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // Snapshot the trap at acceptance so later changes on the inputs are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eret_q      <= 1'b0;
            code_q      <= '0;
            bd_q        <= 1'b0;
            epc_wdata_q <= '0;
            badv_q      <= '0;
            target_q    <= '0;
        end else if (accept) begin
            eret_q      <= exc_eret;
            code_q      <= exc_code;
            bd_q        <= exc_is_ds;
            epc_wdata_q <= exc_is_ds ? (exc_pc - PC_W'(4)) : exc_pc;
            badv_q      <= exc_badvaddr;
            target_q    <= exc_eret ? cp0_epc : EXC_VECTOR;
        end
    end

    // Next-state and Moore strobe decode; every output depends only on registered state
    always_comb begin
        next_state  = state_q;
        busy        = 1'b0;
        flush_all   = 1'b0;
        redir_valid = 1'b0;
        cp0_exc_we  = 1'b0;
        cp0_eret_we = 1'b0;
        cp0_badv_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (exc_valid && !mem_stall) begin
                    next_state = COMMIT;
                end
            end
            COMMIT: begin
                busy       = 1'b1;
                flush_all  = 1'b1;
                next_state = REDIRECT;
                if (eret_q) begin
                    cp0_eret_we = 1'b1;
                end else begin
                    cp0_exc_we  = 1'b1;
                    cp0_badv_we = (code_q == 5'd4) || (code_q == 5'd5);
                end
            end
            REDIRECT: begin
                busy        = 1'b1;
                redir_valid = 1'b1;
                if (if_redir_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign redir_target   = target_q;
    assign cp0_exc_code   = code_q;
    assign cp0_bd         = bd_q;
    assign cp0_epc_wdata  = epc_wdata_q;
    assign cp0_badv_wdata = badv_q;

`ifdef EXC_COMMIT_CNT_EN
    logic [31:0] count_q;

    // Count each non-ERET commit; the counter wraps naturally at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if ((state_q == COMMIT) && !eret_q) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign exc_count = count_q;
`else
    assign exc_count = 32'd0;
`endif

endmodule

// File: tb/tb_exception_commit_ctrl.sv
// tb_exception_commit_ctrl: stimulus pushes an expected-response record per trap
// into a scoreboard queue. A negedge monitor derives each cycle's expected
// outputs from the front record and compares them with the DUT.
module tb_exception_commit_ctrl;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid, exc_eret, exc_is_ds, mem_stall, if_redir_ready;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc, exc_badvaddr, cp0_epc;
    logic        busy, flush_all, redir_valid, cp0_exc_we, cp0_eret_we, cp0_bd, cp0_badv_we;
    logic [4:0]  cp0_exc_code;
    logic [31:0] redir_target, cp0_epc_wdata, cp0_badv_wdata, exc_count;

    typedef struct {
        int          commit_cycle;
        int          ready_delay;
        bit          eret;
        logic [4:0]  code;
        bit          bd;
        logic [31:0] epc_w;
        bit          badv_we;
        logic [31:0] badv;
        logic [31:0] target;
    } exp_rec_t;

    exp_rec_t    exp_q[$];
    exp_rec_t    mon_rec;
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;
    int          exp_count = 0;
    bit          mon_on = 1'b0;
    bit          e_flush, e_busy, e_rv, e_exc_we, e_eret_we, e_badv_we;
    logic [4:0]  code_list [7] = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};

    exception_commit_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .exc_valid      (exc_valid),
        .exc_eret       (exc_eret),
        .exc_code       (exc_code),
        .exc_pc         (exc_pc),
        .exc_is_ds      (exc_is_ds),
        .exc_badvaddr   (exc_badvaddr),
        .cp0_epc        (cp0_epc),
        .mem_stall      (mem_stall),
        .if_redir_ready (if_redir_ready),
        .busy           (busy),
        .flush_all      (flush_all),
        .redir_valid    (redir_valid),
        .redir_target   (redir_target),
        .cp0_exc_we     (cp0_exc_we),
        .cp0_eret_we    (cp0_eret_we),
        .cp0_exc_code   (cp0_exc_code),
        .cp0_bd         (cp0_bd),
        .cp0_epc_wdata  (cp0_epc_wdata),
        .cp0_badv_we    (cp0_badv_we),
        .cp0_badv_wdata (cp0_badv_wdata),
        .exc_count      (exc_count)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle index used by both stimulus and monitor to agree on timing
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void checkOutput(input string name, input logic [31:0] actual,
                                        input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, actual, expected);
        end
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " flush_all"}, 32'(flush_all), 32'd0);
        checkOutput({tag, " redir_valid"}, 32'(redir_valid), 32'd0);
        checkOutput({tag, " redir_target"}, redir_target, 32'd0);
        checkOutput({tag, " cp0_exc_we"}, 32'(cp0_exc_we), 32'd0);
        checkOutput({tag, " cp0_eret_we"}, 32'(cp0_eret_we), 32'd0);
        checkOutput({tag, " cp0_exc_code"}, 32'(cp0_exc_code), 32'd0);
        checkOutput({tag, " cp0_bd"}, 32'(cp0_bd), 32'd0);
        checkOutput({tag, " cp0_epc_wdata"}, cp0_epc_wdata, 32'd0);
        checkOutput({tag, " cp0_badv_we"}, 32'(cp0_badv_we), 32'd0);
        checkOutput({tag, " cp0_badv_wdata"}, cp0_badv_wdata, 32'd0);
        checkOutput({tag, " exc_count"}, exc_count, 32'd0);
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Inputs the controller must ignore while it is busy
    task automatic driveJunk();
        exc_valid = 1'($urandom_range(0, 1));
        exc_eret  = 1'($urandom_range(0, 1));
        exc_code  = 5'($urandom);
        exc_pc    = $urandom;
        exc_is_ds = 1'($urandom_range(0, 1));
        cp0_epc   = $urandom;
        mem_stall = 1'($urandom_range(0, 1));
    endtask

    task automatic idleGap(input int n);
        for (int i = 0; i < n; i++) begin
            exc_valid      = 1'b0;
            mem_stall      = 1'($urandom_range(0, 1));
            if_redir_ready = 1'($urandom_range(0, 1));
            cp0_epc        = $urandom;
            waitCycle();
        end
        exc_valid = 1'b0;
    endtask

    // One trap from presentation to return to idle, with the expectation queued at acceptance
    task automatic applyStimulus(input bit eret, input logic [4:0] code, input logic [31:0] pc,
                                 input bit ds, input logic [31:0] badv, input logic [31:0] epc_in,
                                 input int stall_cycles, input int ready_delay, input bit rst_mid);
        exp_rec_t r;
        exc_valid      = 1'b1;
        exc_eret       = eret;
        exc_code       = code;
        exc_pc         = pc;
        exc_is_ds      = ds;
        exc_badvaddr   = badv;
        cp0_epc        = epc_in;
        if_redir_ready = 1'($urandom_range(0, 1));
        for (int i = 0; i < stall_cycles; i++) begin
            mem_stall = 1'b1;
            waitCycle();
        end
        mem_stall     = 1'b0;
        r.commit_cycle = cyc + 1;
        r.ready_delay  = ready_delay;
        r.eret         = eret;
        r.code         = code;
        r.bd           = ds;
        r.epc_w        = ds ? pc - 32'd4 : pc;
        r.badv_we      = !eret && (code == 5'd4 || code == 5'd5);
        r.badv         = badv;
        r.target       = eret ? epc_in : VEC;
        exp_q.push_back(r);
        for (int k = 1; k <= ready_delay + 2; k++) begin
            waitCycle();
            driveJunk();
            exc_badvaddr   = $urandom;
            if_redir_ready = (k == ready_delay + 2) ? 1'b1 :
                             (k == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (rst_mid && k == 2) begin
                exc_valid = 1'b0;
                #2 rst = 1'b1;
                #1 checkAllZero("reset_in_redirect");
                exp_q.delete();
                exp_count = 0;
                waitCycle();
                rst = 1'b0;
                return;
            end
        end
        waitCycle();
        exc_valid = 1'b0;
    endtask

    // Monitor: expected outputs for this cycle come from the oldest outstanding trap
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            e_flush = 0; e_busy = 0; e_rv = 0; e_exc_we = 0; e_eret_we = 0; e_badv_we = 0;
            if (exp_q.size() > 0) begin
                mon_rec = exp_q[0];
                if (cyc == mon_rec.commit_cycle) begin
                    e_flush   = 1;
                    e_busy    = 1;
                    e_exc_we  = !mon_rec.eret;
                    e_eret_we = mon_rec.eret;
                    e_badv_we = mon_rec.badv_we;
                end else if (cyc > mon_rec.commit_cycle &&
                             cyc <= mon_rec.commit_cycle + 1 + mon_rec.ready_delay) begin
                    e_busy = 1;
                    e_rv   = 1;
                end
            end
            checkOutput("busy", 32'(busy), 32'(e_busy));
            checkOutput("flush_all", 32'(flush_all), 32'(e_flush));
            checkOutput("redir_valid", 32'(redir_valid), 32'(e_rv));
            checkOutput("cp0_exc_we", 32'(cp0_exc_we), 32'(e_exc_we));
            checkOutput("cp0_eret_we", 32'(cp0_eret_we), 32'(e_eret_we));
            checkOutput("cp0_badv_we", 32'(cp0_badv_we), 32'(e_badv_we));
            checkOutput("exc_count", exc_count, 32'(exp_count));
            if (e_exc_we) begin
                checkOutput("cp0_exc_code", 32'(cp0_exc_code), 32'(mon_rec.code));
                checkOutput("cp0_bd", 32'(cp0_bd), 32'(mon_rec.bd));
                checkOutput("cp0_epc_wdata", cp0_epc_wdata, mon_rec.epc_w);
            end
            if (e_badv_we) begin
                checkOutput("cp0_badv_wdata", cp0_badv_wdata, mon_rec.badv);
            end
            if (e_rv) begin
                checkOutput("redir_target", redir_target, mon_rec.target);
            end
            if (exp_q.size() > 0) begin
`ifdef EXC_COMMIT_CNT_EN
                if (cyc == mon_rec.commit_cycle && !mon_rec.eret) exp_count++;
`endif
                if (cyc == mon_rec.commit_cycle + 1 + mon_rec.ready_delay) exp_q.pop_front();
            end
        end
    end

    // Directed scenarios first, then a randomized run against the scoreboard
    initial begin
        rst = 1'b1;
        exc_valid = 0; exc_eret = 0; exc_code = 0; exc_pc = 0; exc_is_ds = 0;
        exc_badvaddr = 0; cp0_epc = 0; mem_stall = 0; if_redir_ready = 0;
        repeat (3) waitCycle();
        checkAllZero("reset_held");
        rst = 1'b0;
        waitCycle();
        checkAllZero("after_reset");
        mon_on = 1'b1;

        applyStimulus(0, 5'd8, 32'hBFC0_1000, 0, 32'h0, 32'h0, 0, 0, 0);
        applyStimulus(0, 5'd4, 32'h8000_0024, 1, 32'h8000_0031, 32'h0, 0, 1, 0);
        applyStimulus(1, 5'd0, 32'h8000_0100, 0, 32'h0, 32'h8000_1234, 0, 5, 0);
        idleGap(2);
        applyStimulus(0, 5'd10, 32'h8000_0200, 0, 32'h0, 32'h0, 3, 0, 0);
        applyStimulus(0, 5'd5, 32'h0000_0000, 1, 32'hDEAD_BEE0, 32'h0, 1, 2, 0);
        applyStimulus(0, 5'd12, 32'h8000_0300, 0, 32'h0, 32'h0, 0, 3, 1);
        idleGap(1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 5'd12, 32'h8000_0400 + 32'(i * 4), 0, 32'h0, 32'h0, 0, 0, 0);
        end
        applyStimulus(1, 5'd0, 32'h0, 0, 32'h0, 32'h8000_0404, 0, 0, 0);
`ifdef EXC_COMMIT_CNT_EN
        checkOutput("count_3ov_1eret", exc_count, 32'd3);
`else
        checkOutput("count_disabled", exc_count, 32'd0);
`endif

        for (int n = 0; n < 40; n++) begin
            applyStimulus(($urandom_range(0, 3) == 0), code_list[$urandom_range(0, 6)],
                          $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), $urandom, $urandom,
                          $urandom_range(0, 3), $urandom_range(0, 4), 0);
            idleGap($urandom_range(0, 2));
        end
        idleGap(3);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
